// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: state encodings,
// instruction field constants, ALU opcodes, operand/PC mux codes and the
// control-word payload the FSM drives onto the datapath.
`timescale 1ns/1ps
package mc_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned SEL_W   = 2;

  // Encodings double as the debug state output
  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // Primary opcodes (IR[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [OP_W-1:0] FN_SLL  = 6'b000000;
  localparam logic [OP_W-1:0] FN_SRL  = 6'b000010;
  localparam logic [OP_W-1:0] FN_SRA  = 6'b000011;
  localparam logic [OP_W-1:0] FN_SLLV = 6'b000100;
  localparam logic [OP_W-1:0] FN_SRLV = 6'b000110;
  localparam logic [OP_W-1:0] FN_SRAV = 6'b000111;
  localparam logic [OP_W-1:0] FN_JR   = 6'b001000;
  localparam logic [OP_W-1:0] FN_ADD  = 6'b100000;
  localparam logic [OP_W-1:0] FN_ADDU = 6'b100001;
  localparam logic [OP_W-1:0] FN_SUB  = 6'b100010;
  localparam logic [OP_W-1:0] FN_SUBU = 6'b100011;
  localparam logic [OP_W-1:0] FN_AND  = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR   = 6'b100101;
  localparam logic [OP_W-1:0] FN_XOR  = 6'b100110;
  localparam logic [OP_W-1:0] FN_NOR  = 6'b100111;
  localparam logic [OP_W-1:0] FN_SLT  = 6'b101010;

  // ALU opcodes
  localparam logic [ALU_W-1:0] ALU_ADD    = 4'h0;
  localparam logic [ALU_W-1:0] ALU_SUB    = 4'h1;
  localparam logic [ALU_W-1:0] ALU_OR     = 4'h2;
  localparam logic [ALU_W-1:0] ALU_SLT    = 4'h3;
  localparam logic [ALU_W-1:0] ALU_AND    = 4'h4;
  localparam logic [ALU_W-1:0] ALU_XOR    = 4'h5;
  localparam logic [ALU_W-1:0] ALU_NOR    = 4'h6;
  localparam logic [ALU_W-1:0] ALU_SL     = 4'h7;
  localparam logic [ALU_W-1:0] ALU_SR     = 4'h8;
  localparam logic [ALU_W-1:0] ALU_SRA    = 4'h9;
  localparam logic [ALU_W-1:0] ALU_PASS_A = 4'hA;
  localparam logic [ALU_W-1:0] ALU_PASS_B = 4'hB;

  // alusrc_b and pc_src mux codes
  localparam logic [SEL_W-1:0] SRCB_REG    = 2'd0;
  localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'd1;
  localparam logic [SEL_W-1:0] SRCB_IMM    = 2'd2;
  localparam logic [SEL_W-1:0] SRCB_BRANCH = 2'd3;
  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'd0;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'd2;

  // Control word driven onto the datapath each cycle
  typedef struct packed {
    logic [ALU_W-1:0] alu_ctr;
    logic             shiftsel;
    logic             alusrc_a;
    logic [SEL_W-1:0] alusrc_b;
    logic             ext_zero;
    logic             pc_write;
    logic [SEL_W-1:0] pc_src;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             retire;
    logic             illegal;
    logic             bus_err;
  } ctrl_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational ALU operation decode.
// Ports: op/funct (IR fields) -> alu_ctr, shiftsel (variable shift),
// ext_zero (logical immediates), illegal_funct (unsupported R-type funct).
// R-type instructions decode funct; everything else decodes the immediate op.
`timescale 1ns/1ps
module alu_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctr,
  output logic       shiftsel,
  output logic       ext_zero,
  output logic       illegal_funct
);

  always_comb begin
    alu_ctr       = ALU_ADD;
    shiftsel      = 1'b0;
    ext_zero      = 1'b0;
    illegal_funct = 1'b0;
    if (op == OP_RTYPE) begin
      case (funct)
        FN_ADD, FN_ADDU: alu_ctr = ALU_ADD;
        FN_SUB, FN_SUBU: alu_ctr = ALU_SUB;
        FN_AND:          alu_ctr = ALU_AND;
        FN_OR:           alu_ctr = ALU_OR;
        FN_XOR:          alu_ctr = ALU_XOR;
        FN_NOR:          alu_ctr = ALU_NOR;
        FN_SLT:          alu_ctr = ALU_SLT;
        FN_SLL:          alu_ctr = ALU_SL;
        FN_SRL:          alu_ctr = ALU_SR;
        FN_SRA:          alu_ctr = ALU_SRA;
        FN_SLLV: begin alu_ctr = ALU_SL;  shiftsel = 1'b1; end
        FN_SRLV: begin alu_ctr = ALU_SR;  shiftsel = 1'b1; end
        FN_SRAV: begin alu_ctr = ALU_SRA; shiftsel = 1'b1; end
        FN_JR:           alu_ctr = ALU_PASS_A;
        default:         illegal_funct = 1'b1;
      endcase
    end else begin
      case (op)
        OP_SLTI: alu_ctr = ALU_SLT;
        OP_ANDI: begin alu_ctr = ALU_AND; ext_zero = 1'b1; end
        OP_ORI:  begin alu_ctr = ALU_OR;  ext_zero = 1'b1; end
        OP_XORI: begin alu_ctr = ALU_XOR; ext_zero = 1'b1; end
        default: alu_ctr = ALU_ADD;
      endcase
    end
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM for the MIPS core.
// Ports: clk, rst (sync, active-high); op/funct from IR, zero from the ALU,
// mem_ready from the memory port. Drives ALU opcode/operand muxes, PC/IR/
// register-file/memory strobes, retire/illegal/bus_err pulses, debug state.
// Outputs decode the current state; memory strobes and branch pc_write also
// depend on same-cycle mem_ready / zero.
`timescale 1ns/1ps
module mc_control
  import mc_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] alu_ctr,
  output logic       shiftsel,
  output logic       alusrc_a,
  output logic [1:0] alusrc_b,
  output logic       ext_zero,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       retire,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_state, timeout, hold;
  ctrl_t            ctl;
  logic [3:0]       dec_alu;
  logic             dec_shift, dec_ext, dec_illegal;

  alu_decode u_alu_decode (
    .op            (op),
    .funct         (funct),
    .alu_ctr       (dec_alu),
    .shiftsel      (dec_shift),
    .ext_zero      (dec_ext),
    .illegal_funct (dec_illegal)
  );

  // Timeout fires only in the limit cycle and only if mem_ready is still low
  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timeout   = (WAIT_LIMIT != 0) && mem_state && !mem_ready &&
                     (wait_cnt == CNT_W'(WAIT_LIMIT));
  // Counter runs only while parked in a memory state; any exit (including a
  // FETCH retry after timeout) leaves it cleared for the next access
  assign hold      = mem_state && !mem_ready && !timeout;

  // State register and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= hold ? wait_cnt + CNT_W'(1) : '0;
    end
  end

  // Next-state and control-word decode
  always_comb begin
    state_d = state_q;
    ctl     = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read = 1'b1;
        ctl.alusrc_b = SRCB_FOUR;
        ctl.alu_ctr  = ALU_ADD;
        if (mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          ctl.pc_src   = PCSRC_ALU;
          state_d      = S_DECODE;
        end else if (timeout) begin
          ctl.mem_read = 1'b0;
          ctl.bus_err  = 1'b1;
        end
      end
      S_DECODE: begin
        ctl.alusrc_b = SRCB_BRANCH;
        ctl.alu_ctr  = ALU_ADD;
        case (op)
          OP_RTYPE:      state_d = S_RTEX;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI:
                         state_d = S_IMMEX;
          default: begin
            ctl.illegal = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctl.alusrc_a = 1'b1;
        ctl.alusrc_b = SRCB_IMM;
        ctl.alu_ctr  = ALU_ADD;
        state_d      = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout) begin
          ctl.mem_read = 1'b0;
          ctl.bus_err  = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.retire     = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEMWR: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
        if (mem_ready) begin
          ctl.retire = 1'b1;
          state_d    = S_FETCH;
        end else if (timeout) begin
          ctl.mem_write = 1'b0;
          ctl.bus_err   = 1'b1;
          state_d       = S_FETCH;
        end
      end
      S_RTEX: begin
        ctl.alusrc_a = 1'b1;
        ctl.alusrc_b = SRCB_REG;
        ctl.alu_ctr  = dec_alu;
        ctl.shiftsel = dec_shift;
        if (funct == FN_JR) begin
          ctl.pc_write = 1'b1;
          ctl.pc_src   = PCSRC_ALU;
          ctl.retire   = 1'b1;
          state_d      = S_FETCH;
        end else if (dec_illegal) begin
          ctl.illegal = 1'b1;
          state_d     = S_FETCH;
        end else begin
          state_d = S_RTWB;
        end
      end
      S_RTWB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
        ctl.retire    = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alusrc_a = 1'b1;
        ctl.alusrc_b = SRCB_REG;
        ctl.alu_ctr  = ALU_SUB;
        ctl.pc_src   = PCSRC_ALUOUT;
        ctl.pc_write = (op == OP_BNE) ? !zero : zero;
        ctl.retire   = 1'b1;
        state_d      = S_FETCH;
      end
      S_IMMEX: begin
        ctl.alusrc_a = 1'b1;
        ctl.alusrc_b = SRCB_IMM;
        ctl.alu_ctr  = dec_alu;
        ctl.ext_zero = dec_ext;
        state_d      = S_IMMWB;
      end
      S_IMMWB: begin
        // op is still held in IR, so the decode reproduces the IMMEX values
        ctl.alu_ctr   = dec_alu;
        ctl.ext_zero  = dec_ext;
        ctl.reg_write = 1'b1;
        ctl.retire    = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        ctl.pc_write = 1'b1;
        ctl.pc_src   = PCSRC_JUMP;
        ctl.retire   = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset silences every strobe immediately so an abandoned instruction writes nothing
    if (rst) begin
      ctl = '0;
    end
  end

  assign alu_ctr    = ctl.alu_ctr;
  assign shiftsel   = ctl.shiftsel;
  assign alusrc_a   = ctl.alusrc_a;
  assign alusrc_b   = ctl.alusrc_b;
  assign ext_zero   = ctl.ext_zero;
  assign pc_write   = ctl.pc_write;
  assign pc_src     = ctl.pc_src;
  assign iord       = ctl.iord;
  assign mem_read   = ctl.mem_read;
  assign mem_write  = ctl.mem_write;
  assign ir_write   = ctl.ir_write;
  assign reg_write  = ctl.reg_write;
  assign reg_dst    = ctl.reg_dst;
  assign mem_to_reg = ctl.mem_to_reg;
  assign retire     = ctl.retire;
  assign illegal    = ctl.illegal;
  assign bus_err    = ctl.bus_err;
  assign state      = rst ? 4'd0 : 4'(state_q);

endmodule

// File: tb/tb_mc_control.sv
// Testbench for mc_control: builds the expected per-cycle control trace of
// each instruction from its class and chosen memory wait counts, drives it,
// and compares every cycle's outputs.
`timescale 1ns/1ps
module tb_mc_control;

  localparam int WL = 4;

  typedef struct packed {
    logic [3:0] state;
    logic [3:0] alu_ctr;
    logic       shiftsel;
    logic       alusrc_a;
    logic [1:0] alusrc_b;
    logic       ext_zero;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       retire;
    logic       illegal;
    logic       bus_err;
  } ctl_t;

  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       ready;
    logic       zero;
    ctl_t       exp;
  } step_t;

  localparam int CL_ILL = 0, CL_R = 1, CL_MEM = 2, CL_BR = 3, CL_IMM = 4, CL_J = 5;

  logic clk = 1'b0;
  logic rst, zero, mem_ready;
  logic [5:0] op, funct;
  logic [3:0] alu_ctr, state;
  logic shiftsel, alusrc_a, ext_zero, pc_write, iord, mem_read, mem_write;
  logic ir_write, reg_write, reg_dst, mem_to_reg, retire, illegal, bus_err;
  logic [1:0] alusrc_b, pc_src;

  ctl_t  obs;
  step_t trace[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  logic [5:0] legal_fn [0:15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                  6'h2a, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
  logic [5:0] rand_op  [0:16] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02,
                                  6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h3f, 6'h0b, 6'h01};

  always #5 clk = ~clk;

  mc_control #(.WAIT_LIMIT(WL), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .alu_ctr(alu_ctr), .shiftsel(shiftsel), .alusrc_a(alusrc_a), .alusrc_b(alusrc_b),
    .ext_zero(ext_zero), .pc_write(pc_write), .pc_src(pc_src), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .retire(retire), .illegal(illegal),
    .bus_err(bus_err), .state(state)
  );

  always_comb begin
    obs            = '0;
    obs.state      = state;
    obs.alu_ctr    = alu_ctr;
    obs.shiftsel   = shiftsel;
    obs.alusrc_a   = alusrc_a;
    obs.alusrc_b   = alusrc_b;
    obs.ext_zero   = ext_zero;
    obs.pc_write   = pc_write;
    obs.pc_src     = pc_src;
    obs.iord       = iord;
    obs.mem_read   = mem_read;
    obs.mem_write  = mem_write;
    obs.ir_write   = ir_write;
    obs.reg_write  = reg_write;
    obs.reg_dst    = reg_dst;
    obs.mem_to_reg = mem_to_reg;
    obs.retire     = retire;
    obs.illegal    = illegal;
    obs.bus_err    = bus_err;
  end

  function automatic logic rbit();
    return 1'($urandom % 2);
  endfunction

  function automatic ctl_t blank(input logic [3:0] st);
    ctl_t c;
    c = '0;
    c.state = st;
    return c;
  endfunction

  function automatic int op_class(input logic [5:0] o);
    case (o)
      6'h00:                                    return CL_R;
      6'h23, 6'h2b:                             return CL_MEM;
      6'h04, 6'h05:                             return CL_BR;
      6'h02:                                    return CL_J;
      6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0e: return CL_IMM;
      default:                                  return CL_ILL;
    endcase
  endfunction

  // R-type funct -> ALU opcode / shift source, per the instruction table
  task automatic rt_map(input logic [5:0] f, output logic [3:0] a, output logic s,
                        output bit legal, output bit jr);
    a = 4'h0; s = 1'b0; legal = 1'b1; jr = 1'b0;
    case (f)
      6'h20, 6'h21: a = 4'h0;
      6'h22, 6'h23: a = 4'h1;
      6'h24: a = 4'h4;
      6'h25: a = 4'h2;
      6'h26: a = 4'h5;
      6'h27: a = 4'h6;
      6'h2a: a = 4'h3;
      6'h00: a = 4'h7;
      6'h02: a = 4'h8;
      6'h03: a = 4'h9;
      6'h04: begin a = 4'h7; s = 1'b1; end
      6'h06: begin a = 4'h8; s = 1'b1; end
      6'h07: begin a = 4'h9; s = 1'b1; end
      6'h08: begin a = 4'hA; jr = 1'b1; end
      default: legal = 1'b0;
    endcase
  endtask

  task automatic imm_map(input logic [5:0] o, output logic [3:0] a, output logic e);
    a = 4'h0; e = 1'b0;
    case (o)
      6'h0a: a = 4'h3;
      6'h0c: begin a = 4'h4; e = 1'b1; end
      6'h0d: begin a = 4'h2; e = 1'b1; end
      6'h0e: begin a = 4'h5; e = 1'b1; end
      default: a = 4'h0;
    endcase
  endtask

  task automatic push(input logic [5:0] o, input logic [5:0] f, input logic rdy,
                      input logic z, input ctl_t c);
    step_t s;
    s.rst = 1'b0; s.op = o; s.funct = f; s.ready = rdy; s.zero = z; s.exp = c;
    trace.push_back(s);
  endtask

  task automatic push_rst(input int n);
    step_t s;
    for (int i = 0; i < n; i++) begin
      s.rst = 1'b1; s.op = 6'($urandom); s.funct = 6'($urandom);
      s.ready = 1'b1; s.zero = rbit(); s.exp = '0;
      trace.push_back(s);
    end
  endtask

  // One memory access: ready arrives after w idle cycles, unless w exceeds the
  // limit, in which case the limit cycle reports bus_err instead.
  task automatic mem_access(input logic [5:0] o, input logic [5:0] f, input logic [3:0] st,
                            input logic wr, input int w, output bit done);
    ctl_t c;
    done = 1'b0;
    for (int i = 0; i <= WL; i++) begin
      c = blank(st);
      c.iord = (st != 4'd0);
      if (st == 4'd0) c.alusrc_b = 2'd1;
      if (i == w) begin
        c.mem_read = ~wr; c.mem_write = wr;
        if (st == 4'd0) begin c.ir_write = 1'b1; c.pc_write = 1'b1; end
        if (wr) c.retire = 1'b1;
        push(o, f, 1'b1, rbit(), c);
        done = 1'b1;
        break;
      end
      if (i == WL) begin
        c.bus_err = 1'b1;
        push(o, f, 1'b0, rbit(), c);
        break;
      end
      c.mem_read = ~wr; c.mem_write = wr;
      push(o, f, 1'b0, rbit(), c);
    end
  endtask

  task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input int fw, input int mw);
    ctl_t c; bit done, legal, jr; logic [3:0] a; logic s, e; int cls;
    mem_access(o, f, 4'd0, 1'b0, fw, done);
    if (!done) return;
    cls = op_class(o);
    c = blank(4'd1); c.alusrc_b = 2'd3;
    if (cls == CL_ILL) c.illegal = 1'b1;
    push(o, f, rbit(), rbit(), c);
    case (cls)
      CL_R: begin
        rt_map(f, a, s, legal, jr);
        c = blank(4'd6); c.alusrc_a = 1'b1; c.alu_ctr = a; c.shiftsel = s;
        if (jr) begin
          c.pc_write = 1'b1; c.retire = 1'b1;
          push(o, f, rbit(), rbit(), c);
        end else if (!legal) begin
          c.illegal = 1'b1;
          push(o, f, rbit(), rbit(), c);
        end else begin
          push(o, f, rbit(), rbit(), c);
          c = blank(4'd7); c.reg_write = 1'b1; c.reg_dst = 1'b1; c.retire = 1'b1;
          push(o, f, rbit(), rbit(), c);
        end
      end
      CL_MEM: begin
        c = blank(4'd2); c.alusrc_a = 1'b1; c.alusrc_b = 2'd2;
        push(o, f, rbit(), rbit(), c);
        mem_access(o, f, (o == 6'h2b) ? 4'd5 : 4'd3, (o == 6'h2b), mw, done);
        if (done && o == 6'h23) begin
          c = blank(4'd4); c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.retire = 1'b1;
          push(o, f, rbit(), rbit(), c);
        end
      end
      CL_BR: begin
        c = blank(4'd8); c.alusrc_a = 1'b1; c.alu_ctr = 4'h1; c.pc_src = 2'd1; c.retire = 1'b1;
        c.pc_write = (o == 6'h04) ? z : ~z;
        push(o, f, rbit(), z, c);
      end
      CL_IMM: begin
        imm_map(o, a, e);
        c = blank(4'd9); c.alusrc_a = 1'b1; c.alusrc_b = 2'd2; c.alu_ctr = a; c.ext_zero = e;
        push(o, f, rbit(), rbit(), c);
        c = blank(4'd10); c.alu_ctr = a; c.ext_zero = e; c.reg_write = 1'b1; c.retire = 1'b1;
        push(o, f, rbit(), rbit(), c);
      end
      CL_J: begin
        c = blank(4'd11); c.pc_write = 1'b1; c.pc_src = 2'd2; c.retire = 1'b1;
        push(o, f, rbit(), rbit(), c);
      end
      default: ;
    endcase
  endtask

  task automatic drive_check(input step_t s, input string tag);
    @(negedge clk);
    rst = s.rst; op = s.op; funct = s.funct; mem_ready = s.ready; zero = s.zero;
    #1;
    checks++;
    assert (obs === s.exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, s.exp);
    end
    cyc++;
  endtask

  task automatic run_trace(input string tag, input int n);
    int lim;
    lim = (n < 0) ? int'(trace.size()) : n;
    for (int i = 0; i < lim && i < int'(trace.size()); i++) drive_check(trace[i], tag);
    trace.delete();
  endtask

  task automatic instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input int fw, input int mw);
    build(o, f, z, fw, mw);
    run_trace(tag, -1);
  endtask

  initial begin
    logic [5:0] ro, rf;
    int fw, mw;
    rst = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;

    push_rst(3);                             run_trace("reset", -1);
    instr("add",        6'h00, 6'h20, 1'b0, 0, 0);
    instr("lw_wait3",   6'h23, 6'h00, 1'b0, 0, 3);
    instr("beq_taken",  6'h04, 6'h00, 1'b1, 0, 0);
    instr("beq_not",    6'h04, 6'h00, 1'b0, 0, 0);
    instr("bne_zero",   6'h05, 6'h00, 1'b1, 0, 0);
    instr("bne_nzero",  6'h05, 6'h00, 1'b0, 0, 0);
    instr("srav",       6'h00, 6'h07, 1'b0, 0, 0);
    instr("sra",        6'h00, 6'h03, 1'b0, 0, 0);
    instr("ori",        6'h0d, 6'h00, 1'b0, 0, 0);
    instr("sw_timeout", 6'h2b, 6'h00, 1'b0, 0, 99);
    instr("ill_op",     6'h3f, 6'h00, 1'b0, 0, 0);
    instr("fetch_tmo",  6'h00, 6'h20, 1'b0, 5, 0);
    instr("fetch_lim",  6'h08, 6'h00, 1'b0, 4, 0);
    instr("lw_lim",     6'h23, 6'h00, 1'b0, 0, 4);
    instr("lw_timeout", 6'h23, 6'h00, 1'b0, 0, 5);
    instr("sw_wait2",   6'h2b, 6'h00, 1'b0, 1, 2);
    instr("jr",         6'h00, 6'h08, 1'b0, 0, 0);
    instr("j",          6'h02, 6'h00, 1'b0, 0, 0);
    instr("ill_funct",  6'h00, 6'h3f, 1'b0, 0, 0);

    // Reset while a load is waiting in its memory phase
    build(6'h23, 6'h00, 1'b0, 0, 3);         run_trace("midop_lw", 5);
    push_rst(1);                             run_trace("midop_rst", -1);
    instr("after_rst",  6'h0c, 6'h00, 1'b0, 0, 0);

    for (int k = 0; k < 120; k++) begin
      ro = rand_op[$urandom_range(0, 16)];
      rf = rbit() ? legal_fn[$urandom_range(0, 15)] : 6'($urandom);
      fw = ($urandom % 4 == 0) ? int'($urandom_range(0, 6)) : 0;
      mw = ($urandom % 3 == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 1));
      instr("random", ro, rf, rbit(), fw, mw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle control FSM for the MIPS core.
- Sequences the shared ALU through fetch/decode/execute/memory/writeback steps:
  - drives alu_ctr/shiftsel and the operand muxes;
  - strobes PC, IR, register-file and memory enables.
- Sits between the instruction register, the memory port, and the datapath that instantiates the ALU.
- Memory accesses use a ready handshake with a programmable timeout.

Parameters:
WAIT_LIMIT, 255, max cycles a memory request may wait for mem_ready before bus_err (0 = no timeout)
CNT_W, 8, wait-counter width (must hold WAIT_LIMIT)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high; one clock
op  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag (same cycle)
mem_ready  in  1  memory completes current read/write
alu_ctr  out  4  ALU opcode (0 add, 1 sub, 2 or, 3 slt, 4 and, 5 xor, 6 nor, 7 sl, 8 sr, 9 sra, A pass a, B pass b)
shiftsel  out  1  1: shift amount from a[4:0]; 0: from shamt
alusrc_a  out  1  0 PC, 1 reg A
alusrc_b  out  2  0 reg B, 1 const 4, 2 ext imm, 3 sign-ext imm<<2
ext_zero  out  1  immediate zero-extended (andi/ori/xori)
pc_write  out  1  load PC
pc_src  out  2  0 ALU result, 1 ALUOut reg, 2 jump target
iord  out  1  memory address: 0 PC, 1 ALUOut
mem_read, mem_write  out  1 each  memory request strobes
ir_write  out  1  load IR
reg_write  out  1  register-file write
reg_dst  out  1  1 rd, 0 rt
mem_to_reg  out  1  1 MDR, 0 ALUOut
retire  out  1  one-cycle pulse: instruction completed
illegal  out  1  one-cycle pulse: unsupported op/funct
bus_err  out  1  one-cycle pulse: memory timeout
state  out  4  current state (debug)

Behaviour:
- Outputs:
  - Moore decode of state, except:
    - pc_write in BRANCH and FETCH;
    - strobes gated by mem_ready.
  - Every output not listed for a state is 0.
- Reset:
  - rst=1 forces next state FETCH and clears the wait counter.
  - While rst=1, all outputs are 0 and state=0.
  - Mid-operation reset abandons the instruction with no writes.
- States:
  - FETCH(0):
    - Outputs: mem_read=1, iord=0, alusrc_a=0, alusrc_b=1, alu_ctr=add.
    - On mem_ready: ir_write=1, pc_write=1, pc_src=0, go DECODE.
    - Otherwise hold.
  - DECODE(1): alusrc_a=0, alusrc_b=3, add (branch target into ALUOut). Dispatch on op:
    - 000000 → RTEX
    - 100011 / 101011 → MEMADR
    - 000100 / 000101 → BRANCH
    - 000010 → JUMP
    - 001000, 001001, 001010, 001100, 001101, 001110 → IMMEX
    - any other op: illegal=1, → FETCH
  - MEMADR(2): alusrc_a=1, alusrc_b=2, add. lw → MEMRD, sw → MEMWR.
  - MEMRD(3): mem_read=1, iord=1; on mem_ready → MEMWB.
  - MEMWB(4): reg_write=1, reg_dst=0, mem_to_reg=1, retire=1 → FETCH.
  - MEMWR(5): mem_write=1, iord=1; on mem_ready: retire=1 → FETCH.
  - RTEX(6): alusrc_a=1, alusrc_b=0. alu_ctr by funct:
    - add/addu→0, sub/subu→1, and→4, or→2, xor→5, nor→6, slt→3
    - sll→7, srl→8, sra→9 (shiftsel=0)
    - sllv→7, srlv→8, srav→9 (shiftsel=1)
    - jr: alu_ctr=A, pc_write=1, pc_src=0, retire=1 → FETCH
    - unknown funct: illegal=1 → FETCH
    - all others → RTWB
  - RTWB(7): reg_write=1, reg_dst=1, mem_to_reg=0, retire=1 → FETCH.
  - BRANCH(8):
    - Outputs: alusrc_a=1, alusrc_b=0, sub, pc_src=1, retire=1 → FETCH.
    - pc_write = zero for beq, !zero for bne.
  - IMMEX(9): alusrc_a=1, alusrc_b=2.
    - addi/addiu: add
    - slti: slt
    - andi: and, ext_zero=1
    - ori: or, ext_zero=1
    - xori: xor, ext_zero=1
    - → IMMWB
  - IMMWB(10): alu_ctr/ext_zero held from IMMEX; reg_write=1, reg_dst=0, mem_to_reg=0, retire=1 → FETCH.
  - JUMP(11): pc_write=1, pc_src=2, retire=1 → FETCH.
- Wait counter:
  - Clears on entry to FETCH/MEMRD/MEMWR and increments each cycle waiting there.
  - If WAIT_LIMIT≠0 and the counter reaches WAIT_LIMIT without mem_ready: bus_err=1, strobes deasserted that cycle, → FETCH.
  - A FETCH timeout retries the same PC.
  - mem_ready in the limit cycle wins over timeout.
  - mem_ready outside memory states is ignored.
- Latencies (zero-wait memory):
  - R-type / imm: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch / j: 3 cycles

Decomposition:
- Package mc_pkg holds:
  - state encodings;
  - opcode/funct constants;
  - ALU opcode constants (values as in alu_ctr port);
  - alusrc_b/pc_src codes.
- One sub-module alu_decode: combinational funct/op → {alu_ctr, shiftsel, ext_zero, illegal_funct}. Used by RTEX/IMMEX/IMMWB.

Test Plan:
- rst held 3 cycles, mem_ready=1 → state=0, all outputs 0; first cycle after release: mem_read=1, ir_write=1, pc_write=1.
- add (op 0, funct 100000), zero-wait → states 0,1,6,7; RTWB: reg_write=1, reg_dst=1, alu_ctr=0 in RTEX; retire once in cycle 4.
- lw with mem_ready delayed 3 cycles in MEMRD → mem_read, iord=1 held 4 cycles; then MEMWB: mem_to_reg=1, reg_write=1; total 8 cycles.
- beq with zero=1 → BRANCH: pc_write=1, pc_src=1; same with zero=0 → pc_write=0; bne inverted.
- srav (funct 000111) → alu_ctr=9, shiftsel=1; sra (000011) → alu_ctr=9, shiftsel=0; ori → alu_ctr=2, ext_zero=1 in IMMEX and IMMWB.
- WAIT_LIMIT=4, sw with mem_ready never asserted → bus_err pulse after 4 wait cycles, no retire, next state FETCH; op 111111 → illegal pulse in DECODE, no writes.
